// File: rtl/score_display_if.sv
`default_nettype none
// ============================================================================
// Interface : score_display_if
// Brief     : Score load/status handshake plus the pixel scan and glyph ROM
//             signals of score_display_ctrl.
// Rev       : 1.0
// ============================================================================
interface score_display_if #(
  parameter int SCORE_W = 14
);
  logic [SCORE_W-1:0] score;
  logic               score_load;
  logic               busy;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic               glyph_on;
  logic [3:0]         letra;
  logic [3:0]         xcoord;
  logic [3:0]         ycoord;
  logic               pixel_on;

  modport master (
    output score, score_load, pix_x, pix_y, glyph_on,
    input  busy, letra, xcoord, ycoord, pixel_on
  );

  modport slave (
    input  score, score_load, pix_x, pix_y, glyph_on,
    output busy, letra, xcoord, ycoord, pixel_on
  );
endinterface
`default_nettype wire

// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module : score_display_ctrl
// Brief  : Binary-to-BCD score conversion (double dabble) and glyph ROM
//          sequencing for a NUM_DIGITS-wide decimal score window.
// Config : LEADING_ZERO_BLANK_EN - blank zero digits left of the first
//          nonzero digit (last digit always drawn).
// Rev    : 1.0
// ============================================================================
module score_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int ORG_X      = 16,
  parameter int ORG_Y      = 8,
  parameter int SCALE_LOG2 = 1
) (
  input wire            clk,
  input wire            reset,
  score_display_if.slave bus
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SR_W  = BCD_W + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int G     = 8 << SCALE_LOG2;
  localparam int H     = 7 << SCALE_LOG2;
  localparam int X_END = ORG_X + NUM_DIGITS * G;
  localparam int Y_END = ORG_Y + H;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int MAX_VAL = pow10(NUM_DIGITS) - 1;

  function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] v);
    if (64'(v) > 64'(MAX_VAL)) return SCORE_W'(MAX_VAL);
    return v;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t             state;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_adj;
  logic [CNT_W-1:0]   cnt;
  logic               busy_r;
  logic               pend;
  logic [SCORE_W-1:0] pend_score;
  logic [BCD_W-1:0]   disp;

  // Double-dabble correction of every BCD nibble before the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr[SCORE_W + 4*i +: 4] >= 4'd5)
        sr_adj[SCORE_W + 4*i +: 4] = sr[SCORE_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sr         <= '0;
      cnt        <= '0;
      busy_r     <= 1'b0;
      pend       <= 1'b0;
      pend_score <= '0;
      disp       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.score_load) begin
            sr     <= {{BCD_W{1'b0}}, clamp(bus.score)};
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= S_CONV;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_CONV: begin
          sr  <= {sr_adj[SR_W-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(SCORE_W - 1)) state <= S_COMMIT;
          if (bus.score_load) begin
            pend       <= 1'b1;
            pend_score <= bus.score;
          end
        end
        S_COMMIT: begin
          disp <= sr[SR_W-1 -: BCD_W];
          // busy is held through COMMIT and drops one cycle later in IDLE
          if (bus.score_load || pend) begin
            sr    <= {{BCD_W{1'b0}}, clamp(bus.score_load ? bus.score : pend_score)};
            cnt   <= '0;
            pend  <= 1'b0;
            state <= S_CONV;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [9:0] dx;
  logic [9:0] dy;
  logic [9:0] dig_idx;
  logic       in_win;
  logic [3:0] code;
  logic [3:0] xg;
  logic [3:0] yg;
  logic       blank_sel;

  assign dx      = bus.pix_x - 10'(ORG_X);
  assign dy      = bus.pix_y - 10'(ORG_Y);
  assign dig_idx = dx >> (3 + SCALE_LOG2);
  assign xg      = 4'((dx >> SCALE_LOG2) & 10'd7);
  assign yg      = 4'(dy >> SCALE_LOG2);
  assign in_win  = (int'(bus.pix_x) >= ORG_X) && (int'(bus.pix_x) < X_END) &&
                   (int'(bus.pix_y) >= ORG_Y) && (int'(bus.pix_y) < Y_END);

  // Digit 0 is the most significant nibble of the display register
  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == 10'(i)) code = disp[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  lead;

  always_comb begin
    lead      = 1'b1;
    blank_vec = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead         = lead & (disp[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      blank_vec[i] = lead & (i != NUM_DIGITS - 1);
    end
  end

  always_comb begin
    blank_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx == 10'(i)) blank_sel = blank_vec[i];
    end
  end
`else
  assign blank_sel = 1'b0;
`endif

  logic [3:0] letra_r;
  logic [3:0] xcoord_r;
  logic [3:0] ycoord_r;
  logic       in_win_d;
  logic       blank_d;
  logic       pixel_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      letra_r  <= '0;
      xcoord_r <= '0;
      ycoord_r <= '0;
      in_win_d <= 1'b0;
      blank_d  <= 1'b0;
      pixel_r  <= 1'b0;
    end else begin
      if (in_win) begin
        letra_r  <= code;
        xcoord_r <= xg;
        ycoord_r <= yg;
      end else begin
        letra_r  <= '0;
        xcoord_r <= '0;
        ycoord_r <= '0;
      end
      in_win_d <= in_win;
      blank_d  <= blank_sel;
      // glyph_on answers the stage-1 address registered on the previous edge
      pixel_r  <= in_win_d & bus.glyph_on & ~blank_d;
    end
  end

  assign bus.letra    = letra_r;
  assign bus.xcoord   = xcoord_r;
  assign bus.ycoord   = ycoord_r;
  assign bus.pixel_on = pixel_r;
  assign bus.busy     = busy_r;

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_score_display_ctrl
// Brief  : Self-checking bench for score_display_ctrl against an arithmetic
//          model of the score window and a stand-in glyph ROM.
// Rev    : 1.0
// ============================================================================
module tb_score_display_ctrl;
  localparam int ND    = 4;
  localparam int ORG_X = 16;
  localparam int ORG_Y = 8;
  localparam int G     = 16;
  localparam int H     = 14;
  localparam int MAXV  = 9999;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rom_force = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   disp_val = 0;

  always #5 clk = ~clk;

  score_display_if #(.SCORE_W(14)) bus ();

  score_display_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic rom_bit(input logic [3:0] l, input logic [3:0] x, input logic [3:0] y);
    return ((int'(l) + 3 * int'(x) + 5 * int'(y)) % 4) != 0;
  endfunction

  assign bus.glyph_on = rom_force | rom_bit(bus.letra, bus.xcoord, bus.ycoord);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pix(input int x, input int y, output int win, output int l,
                           output int xc, output int yc, output int bl);
    int dx, d, p;
    win = (x >= ORG_X && x < ORG_X + ND * G && y >= ORG_Y && y < ORG_Y + H) ? 1 : 0;
    l = 0; xc = 0; yc = 0; bl = 0;
    if (win != 0) begin
      dx = x - ORG_X;
      d  = dx / G;
      xc = (dx / 2) % 8;
      yc = (y - ORG_Y) / 2;
      p  = pow10(ND - 1 - d);
      l  = (disp_val / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
      bl = (d < ND - 1 && disp_val < p) ? 1 : 0;
`endif
    end
  endtask

  task automatic scan(input int x, input int y);
    int   win, l, xc, yc, bl;
    logic exp_on;
    model_pix(x, y, win, l, xc, yc, bl);
    bus.pix_x = 10'(x);
    bus.pix_y = 10'(y);
    tick();
    check_eq("letra", bus.letra, l);
    check_eq("xcoord", bus.xcoord, xc);
    check_eq("ycoord", bus.ycoord, yc);
    exp_on = (win != 0) && (rom_force || rom_bit(4'(l), 4'(xc), 4'(yc))) && (bl == 0);
    tick();
    check_eq("pixel_on", bus.pixel_on, exp_on);
  endtask

  task automatic check_digits();
    for (int d = 0; d < ND; d++) scan(ORG_X + d * G, ORG_Y);
  endtask

  task automatic load_wait(input int v);
    int cnt;
    bus.score      = 14'(v);
    bus.score_load = 1'b1;
    tick();
    bus.score_load = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check_eq("busy_cycles", cnt, 16);
    disp_val = (v > MAXV) ? MAXV : v;
  endtask

  initial begin
    int cnt;
    logic saw1, saw2;
    bus.score      = '0;
    bus.score_load = 1'b0;
    bus.pix_x      = 10'd20;
    bus.pix_y      = 10'd10;

    // Reset state
    repeat (3) tick();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_letra", bus.letra, 0);
    check_eq("rst_xcoord", bus.xcoord, 0);
    check_eq("rst_ycoord", bus.ycoord, 0);
    check_eq("rst_pixel_on", bus.pixel_on, 0);
    reset = 1'b0;
    tick();
    check_digits();

    // Basic conversion and pixel mapping
    load_wait(1234);
    check_digits();
    scan(48, 8);
    scan(63, 21);

    // Clamp and window edges
    load_wait(16383);
    check_digits();
    scan(15, 8);
    scan(80, 8);
    scan(79, 21);
    scan(16, 22);

    // Loads during a conversion: last one wins, busy never drops
    bus.pix_x = 10'd16;
    bus.pix_y = 10'd8;
    bus.score = 14'd1111;
    bus.score_load = 1'b1;
    tick();
    bus.score_load = 1'b0;
    cnt = 0; saw1 = 1'b0; saw2 = 1'b0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      if (bus.letra == 4'd1) saw1 = 1'b1;
      if (bus.letra == 4'd2) saw2 = 1'b1;
      bus.score_load = (cnt == 3 || cnt == 6);
      bus.score      = (cnt == 3) ? 14'd2222 : 14'd3333;
      tick();
    end
    bus.score_load = 1'b0;
    check_eq("busy_run", cnt, 31);
    check_eq("saw_1111", saw1, 1);
    check_eq("saw_2222", saw2, 0);
    disp_val = 3333;
    check_digits();

    // Reset mid-conversion with a pending load
    bus.pix_x = 10'd20;
    bus.pix_y = 10'd10;
    bus.score = 14'd5678;
    bus.score_load = 1'b1;
    tick();
    bus.score = 14'd4321;
    tick();
    bus.score_load = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_pixel_on", bus.pixel_on, 0);
    check_eq("abort_letra", bus.letra, 0);
    disp_val = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) cnt++;
      tick();
    end
    check_eq("abort_no_restart", cnt, 0);
    check_digits();

    // Leading-zero behaviour with the glyph forced on
    rom_force = 1'b1;
    load_wait(7);
    scan(20, 10);
    scan(70, 10);
    rom_force = 1'b0;

    // Randomized scores and scan positions
    for (int k = 0; k < 8; k++) begin
      load_wait(int'($urandom_range(0, 16383)));
      for (int j = 0; j < 10; j++)
        scan(int'($urandom_range(0, 99)), int'($urandom_range(0, 29)));
    end
    load_wait(0);
    check_digits();
    scan(70, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
